// File: rtl/seven_seg_controller_if.sv
// ============================================================================
// Module      : seven_seg_controller_if
// Description : Host-side write port and display-side drive of the
//               four-digit seven-segment controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seven_seg_controller_if;
    logic        enable;
    logic [15:0] data;
    logic [3:0]  dp;
    logic        load;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp_n;
    logic        frame_done;

    modport master (
        output enable, data, dp, load,
        input  anode, seg, dp_n, frame_done
    );

    modport slave (
        input  enable, data, dp, load,
        output anode, seg, dp_n, frame_done
    );
endinterface

`default_nettype wire

// File: rtl/seven_seg_controller.sv
// ============================================================================
// Module      : seven_seg_controller
// Description : Four-digit common-anode scan controller with a double-buffered
//               display register updated only at frame boundaries.
//               Optional macro SEG_GHOST_BLANK_EN inserts DEAD_CYCLES of blank
//               time at the start of every digit slot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_seg_controller #(
    parameter int DIV_COUNT   = 50000,
    parameter int DEAD_CYCLES = 1000
) (
    input  logic                   clock,
    input  logic                   reset,
    seven_seg_controller_if.slave  bus
);

    localparam int               CNT_W    = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_COUNT - 1);
`ifdef SEG_GHOST_BLANK_EN
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
`ifdef SEG_GHOST_BLANK_EN
        S_BLANK = 2'd1,
`endif
        S_ON    = 2'd2
    } state_t;

`ifdef SEG_GHOST_BLANK_EN
    localparam state_t SLOT_START = S_BLANK;
`else
    localparam state_t SLOT_START = S_ON;
`endif

    state_t           r_state;
    logic [1:0]       r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_shadow;
    logic [3:0]       r_dp_shadow;
    logic [15:0]      r_disp;
    logic [3:0]       r_dp;
    logic             r_pending;
    logic [3:0]       r_anode;
    logic [6:0]       r_seg;
    logic             r_dp_n;
    logic             r_frame_done;

    logic [15:0]      w_disp_next;
    logic [3:0]       w_dp_next;
    logic [15:0]      w_shadow_next;
    logic [3:0]       w_dp_shadow_next;
    logic             w_pending_next;
    logic             w_slot_end;
    logic [3:0]       w_nibble;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // The frame_done register marks the boundary cycle; the first digit of the
    // new frame decodes from the post-boundary value so no frame ever tears.
    always_comb begin
        w_disp_next      = r_disp;
        w_dp_next        = r_dp;
        w_shadow_next    = r_shadow;
        w_dp_shadow_next = r_dp_shadow;
        w_pending_next   = r_pending;
        if (bus.load) begin
            w_shadow_next    = bus.data;
            w_dp_shadow_next = bus.dp;
        end
        if ((r_state == S_IDLE) || r_frame_done) begin
            if (bus.load) begin
                w_disp_next    = bus.data;
                w_dp_next      = bus.dp;
                w_pending_next = 1'b0;
            end else if (r_frame_done && r_pending) begin
                w_disp_next    = r_shadow;
                w_dp_next      = r_dp_shadow;
                w_pending_next = 1'b0;
            end
        end else if (bus.load) begin
            w_pending_next = 1'b1;
        end
    end

    assign w_slot_end = (r_cnt == CNT_LAST);
    assign w_nibble   = w_disp_next[{r_idx, 2'b00} +: 4];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_idx        <= 2'd0;
            r_cnt        <= '0;
            r_shadow     <= 16'h0000;
            r_dp_shadow  <= 4'h0;
            r_disp       <= 16'h0000;
            r_dp         <= 4'h0;
            r_pending    <= 1'b0;
            r_anode      <= 4'b1111;
            r_seg        <= 7'h7F;
            r_dp_n       <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_shadow    <= w_shadow_next;
            r_dp_shadow <= w_dp_shadow_next;
            r_disp      <= w_disp_next;
            r_dp        <= w_dp_next;
            r_pending   <= w_pending_next;

            if (!bus.enable) begin
                r_state      <= S_IDLE;
                r_idx        <= 2'd0;
                r_cnt        <= '0;
                r_anode      <= 4'b1111;
                r_seg        <= 7'h7F;
                r_dp_n       <= 1'b1;
                r_frame_done <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state      <= SLOT_START;
                        r_idx        <= 2'd0;
                        r_cnt        <= '0;
                        r_anode      <= 4'b1111;
                        r_seg        <= 7'h7F;
                        r_dp_n       <= 1'b1;
                        r_frame_done <= 1'b0;
                    end
`ifdef SEG_GHOST_BLANK_EN
                    S_BLANK: begin
                        r_anode      <= 4'b1111;
                        r_seg        <= 7'h7F;
                        r_dp_n       <= 1'b1;
                        r_frame_done <= 1'b0;
                        r_cnt        <= r_cnt + 1'b1;
                        if (r_cnt == DEAD_LAST) begin
                            r_state <= S_ON;
                        end
                    end
`endif
                    S_ON: begin
                        r_anode      <= ~(4'b0001 << r_idx);
                        r_seg        <= decode(w_nibble);
                        r_dp_n       <= ~w_dp_next[r_idx];
                        r_frame_done <= (r_idx == 2'd3) && w_slot_end;
                        if (w_slot_end) begin
                            r_cnt   <= '0;
                            r_idx   <= r_idx + 2'd1;
                            r_state <= SLOT_START;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state      <= S_IDLE;
                        r_idx        <= 2'd0;
                        r_cnt        <= '0;
                        r_anode      <= 4'b1111;
                        r_seg        <= 7'h7F;
                        r_dp_n       <= 1'b1;
                        r_frame_done <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.anode      = r_anode;
    assign bus.seg        = r_seg;
    assign bus.dp_n       = r_dp_n;
    assign bus.frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_controller.sv
// ============================================================================
// Module      : tb_seven_seg_controller
// Description : Directed bench for seven_seg_controller (DIV_COUNT=8,
//               DEAD_CYCLES=2); honours SEG_GHOST_BLANK_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seven_seg_controller;

    localparam int DIV = 8;
`ifdef SEG_GHOST_BLANK_EN
    localparam int DEAD = 2;
`else
    localparam int DEAD = 0;
`endif
    localparam logic [12:0] OFF = {4'hF, 7'h7F, 1'b1, 1'b0};

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    seven_seg_controller_if bus ();

    seven_seg_controller #(
        .DIV_COUNT   (8),
        .DEAD_CYCLES (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [12:0] obs;
    assign obs = {bus.anode, bus.seg, bus.dp_n, bus.frame_done};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0:    return 7'b1000000;
            4'h1:    return 7'b1111001;
            4'h8:    return 7'b0000000;
            4'hA:    return 7'b0001000;
            4'hF:    return 7'b0001110;
            default: return 7'bxxxxxxx;
        endcase
    endfunction

    // p = output cycle index since the scan started (p=0 is slot 0, cnt 0)
    function automatic logic [12:0] exp_vec(input int p, input logic [15:0] d,
                                            input logic [3:0] dv);
        int slot;
        int c;
        logic [3:0] sel;
        if (p < 0) return OFF;
        slot = (p / DIV) % 4;
        c    = p % DIV;
        if (c < DEAD) return OFF;
        sel = 4'b0001 << slot;
        return {~sel, seg_of(d[slot*4 +: 4]), ~dv[slot], (slot == 3 && c == DIV - 1)};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        bus.enable = 1'b0;
        bus.load   = 1'b0;
        bus.data   = 16'h0000;
        bus.dp     = 4'h0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [12:0] e;
        reset      = 1'b0;
        bus.enable = 1'b1;
        bus.load   = 1'b1;
        bus.data   = 16'h8A10;
        bus.dp     = 4'hF;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs !== OFF) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got %b want %b", i, obs, OFF);
            end
        end
        bus.load = 1'b0;
        reset    = 1'b1;
        for (int k = 1; k <= DEAD + 3; k++) begin
            tick();
            e = exp_vec(k - 2, 16'h0000, 4'h0);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset_release k=%0d got %b want %b", k, obs, e);
            end
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== OFF) begin
            errors++;
            $display("FAIL reset_async got %b want %b", obs, OFF);
        end
        tick();
        bus.enable = 1'b0;
    endtask

    task automatic test_scan();
        logic [12:0] e;
        int fd;
        fd = 0;
        do_reset();
        bus.data = 16'h8A10;
        bus.dp   = 4'b0101;
        bus.load = 1'b1;
        tick();
        bus.load   = 1'b0;
        bus.data   = 16'h0000;
        bus.dp     = 4'h0;
        bus.enable = 1'b1;
        for (int k = 0; k <= 64; k++) begin
            tick();
            e = exp_vec(k - 1, 16'h8A10, 4'b0101);
            if (bus.frame_done === 1'b1) fd++;
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL scan p=%0d got %b want %b", k - 1, obs, e);
            end
        end
        checks++;
        if (fd !== 2) begin
            errors++;
            $display("FAIL scan_frame_done_count got %0d want 2", fd);
        end
        bus.enable = 1'b0;
    endtask

    task automatic test_tear_free();
        logic [12:0] e;
        int p;
        do_reset();
        bus.enable = 1'b1;
        for (int k = 0; k <= 65; k++) begin
            tick();
            p = k - 1;
            e = (p < 32) ? exp_vec(p, 16'h0000, 4'h0) : exp_vec(p, 16'hFFFF, 4'hF);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL tear_free p=%0d got %b want %b", p, obs, e);
            end
            if (p == 10) begin
                bus.load = 1'b1;
                bus.data = 16'hFFFF;
                bus.dp   = 4'hF;
            end else if (p == 11) begin
                bus.load = 1'b0;
                bus.data = 16'h0000;
                bus.dp   = 4'h0;
            end
        end
        bus.enable = 1'b0;
    endtask

    task automatic test_boundary();
        logic [12:0] e;
        int p;
        do_reset();
        bus.enable = 1'b1;
        for (int k = 0; k <= 96; k++) begin
            tick();
            p = k - 1;
            e = (p < 32) ? exp_vec(p, 16'h0000, 4'h0) : exp_vec(p, 16'h1111, 4'b1000);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL boundary p=%0d got %b want %b", p, obs, e);
            end
            if (p == 31) begin
                bus.load = 1'b1;
                bus.data = 16'h1111;
                bus.dp   = 4'b1000;
            end else if (p == 32) begin
                bus.load = 1'b0;
                bus.data = 16'h0000;
                bus.dp   = 4'h0;
                checks++;
                if (dut.r_pending !== 1'b0) begin
                    errors++;
                    $display("FAIL boundary_pending got %b want 0", dut.r_pending);
                end
            end
        end
        bus.enable = 1'b0;
    endtask

    task automatic test_disable();
        logic [12:0] e;
        int p;
        do_reset();
        bus.data = 16'h8A10;
        bus.dp   = 4'b0011;
        bus.load = 1'b1;
        tick();
        bus.load   = 1'b0;
        bus.enable = 1'b1;
        for (int k = 0; k <= 21; k++) begin
            tick();
            p = k - 1;
            e = exp_vec(p, 16'h8A10, 4'b0011);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL disable_pre p=%0d got %b want %b", p, obs, e);
            end
            if (p == 17) begin
                bus.load = 1'b1;
                bus.data = 16'hFFFF;
                bus.dp   = 4'h0;
            end else if (p == 18) begin
                bus.load = 1'b0;
                bus.data = 16'h0000;
            end
        end
        bus.enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (obs !== OFF) begin
                errors++;
                $display("FAIL disable_off cyc=%0d got %b want %b", i, obs, OFF);
            end
        end
        bus.enable = 1'b1;
        for (int k = 0; k <= 64; k++) begin
            tick();
            p = k - 1;
            e = (p < 32) ? exp_vec(p, 16'h8A10, 4'b0011) : exp_vec(p, 16'hFFFF, 4'h0);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL disable_resume p=%0d got %b want %b", p, obs, e);
            end
        end
        bus.enable = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b0;
        bus.enable = 1'b0;
        bus.load   = 1'b0;
        bus.data   = 16'h0000;
        bus.dp     = 4'h0;
        test_reset();
        test_scan();
        test_tear_free();
        test_boundary();
        test_disable();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached without completing");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/seven_seg_controller.md
# seven_seg_controller

Sequences the four-digit, common-anode seven-segment display: divides the system clock into digit slots, rotates a single active anode, decodes the selected hex nibble into cathode drive, and inserts optional anti-ghosting blank time between digits. It replaces the free-running anode ring with a controlled scan. It also owns a double-buffered display register, so host writes take effect only at frame boundaries and a frame never shows a mix of old and new digits.

## Interface
- DIV_COUNT, 50000, clock cycles per digit slot; legal range is DIV_COUNT ≥ 2.
- DEAD_CYCLES, 1000, blank cycles at the start of each slot; legal range is 1 ≤ DEAD_CYCLES < DIV_COUNT.
- Ports:
  - clock  in  1  system clock; one clock domain, rising edge.
  - reset  in  1  asynchronous, active-low reset.
  - enable  in  1  scan enable.
  - data  in  16  four hex nibbles; data[3:0] is the rightmost digit (anode[0]).
  - dp  in  4  decimal points, active-high; dp[i] belongs to digit i.
  - load  in  1  single-cycle write strobe for data/dp.
  - anode  out  4  digit select, active-low.
  - seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
  - dp_n  out  1  decimal-point cathode, active-low.
  - frame_done  out  1  one-cycle pulse at the end of each complete 4-digit frame.

## Operation
- **State machine:** IDLE, BLANK, ON.
  - IDLE: all outputs are off.
  - IDLE → BLANK when enable is 1 (→ ON when the macro is undefined). idx=0, cnt=0.
  - BLANK: anode=4'b1111 and seg=7'h7F for cycles cnt=0..DEAD_CYCLES-1, then → ON.
  - ON: anode[idx]=0 with all other anodes 1; seg=decode(nibble idx); dp_n=~dp_reg[idx]. Lasts until cnt=DIV_COUNT-1.
  - End of slot: cnt→0 and idx→idx+1 mod 4; the next state is BLANK (or ON).
- **Scan order:** digit 0 → 1 → 2 → 3 → 0. digit 0 is the first digit after enable.
- **Decode** (standard hex, active-low): 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110.
- **Buffering:**
  - load=1 captures data/dp into the shadow register and sets pending.
  - At a frame boundary with pending=1: disp_reg ← shadow, pending ← 0.
  - A boundary is the last cycle of the digit-3 slot, i.e. the same cycle frame_done is high.
  - load coincident with a boundary: that cycle's data/dp goes directly to disp_reg, and pending stays 0.
  - In IDLE, load writes shadow and disp_reg together.
- **enable dropped mid-frame:** the next cycle is IDLE with all outputs off and idx/cnt cleared. No frame_done is issued. pending is kept and is applied at the first boundary after re-enable.
- **Width rules:**
  - cnt is $clog2(DIV_COUNT) bits.
  - idx is 2 bits and wraps naturally.
  - No arithmetic is performed on data.

## Timing
- **Reset values (asynchronous, while reset=0):**
  - anode=4'b1111, seg=7'h7F, dp_n=1, frame_done=0.
  - shadow=0, disp_reg=0, dp_reg=0, pending=0, idx=0, cnt=0, state=IDLE.
- **Output registers:** all outputs are registered. They are one cycle behind state/cnt.
- **Slot length:** exactly DIV_COUNT cycles with anode low, or DIV_COUNT-DEAD_CYCLES cycles with the macro defined.
- **Frame length:** exactly 4·DIV_COUNT cycles.
- **frame_done:** high for exactly 1 cycle per frame.
- **Load-to-display latency:** at most one frame plus one cycle after the boundary.
- **Reset mid-operation:** outputs go off immediately, with no clock required. Scanning resumes at digit 0 on the first clock after release when enable=1.

## Configuration
- SEG_GHOST_BLANK_EN defined: the BLANK state exists, and DEAD_CYCLES of all-off are inserted at the start of every slot.
- SEG_GHOST_BLANK_EN undefined:
  - BLANK and the DEAD_CYCLES logic are compiled out, and DEAD_CYCLES is ignored.
  - The scan transitions IDLE→ON and ON→ON, with adjacent anodes switching in the same cycle.

## Test plan
All scenarios use DIV_COUNT=8 and DEAD_CYCLES=2.
- **Reset:** hold reset=0 with enable=1 → anode=1111, seg=1111111, dp_n=1, frame_done=0 throughout. Release reset → digit 0 is active on the 2nd cycle after release (plus DEAD_CYCLES with the macro defined).
- **Scan:** load data=16'h8A10 in IDLE, then enable → per slot, seg shows 1000000 (digit 0), 1111001, 0001000, 0000000 on anodes 1110, 1101, 1011, 0111. frame_done pulses every 32 cycles.
- **Blanking (macro defined):** each slot shows 2 cycles of anode=1111, then 6 cycles active. With the macro undefined, anode is never 1111 while enabled.
- **Tear-free update:** load 16'hFFFF during the digit-1 slot of a frame showing 16'h0000 → digits 2 and 3 still show 1000000. The next frame shows 0001110 on all digits.
- **Boundary coincidence:** load 16'h1111 on the frame_done cycle → the next frame shows 1111001 on all digits, and pending=0 afterwards.
- **Disable mid-frame:** drop enable during digit 2 → outputs are off on the next cycle, with no frame_done. Re-enable → the scan restarts at anode=1110.
